// File: rtl/mmio_pkg.sv
// Shared constants for the data-memory / MMIO block: register offsets,
// CTRL bit positions, default window base and the address-decode helper.
package mmio_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h0000_7F00;

    localparam logic [31:0] OFF_LED   = 32'h00;
    localparam logic [31:0] OFF_SW    = 32'h04;
    localparam logic [31:0] OFF_COUNT = 32'h08;
    localparam logic [31:0] OFF_CTRL  = 32'h0C;
    localparam logic [31:0] OFF_CMP   = 32'h10;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_PEND = 1;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_LED,
        SEL_SW,
        SEL_COUNT,
        SEL_CTRL,
        SEL_CMP
    } sel_e;

    // Maps a word-aligned byte address onto one of the MMIO registers.
    function automatic sel_e decode_mmio(input logic [31:0] aligned,
                                         input logic [31:0] base);
        sel_e s;
        s = SEL_NONE;
        if (aligned == base + OFF_LED)        s = SEL_LED;
        else if (aligned == base + OFF_SW)    s = SEL_SW;
        else if (aligned == base + OFF_COUNT) s = SEL_COUNT;
        else if (aligned == base + OFF_CTRL)  s = SEL_CTRL;
        else if (aligned == base + OFF_CMP)   s = SEL_CMP;
        return s;
    endfunction

endpackage

// File: rtl/dm_ram.sv
// Word-wide data RAM: synchronous write, asynchronous read. Contents are not
// reset, so words read as undefined until first written.
module dm_ram #(
    parameter int WORDS = 1024,
    parameter int AW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] word_addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) mem[word_addr] <= wdata;
    end

    assign rdata = mem[word_addr];

endmodule

// File: rtl/dmem_mmio.sv
// Data memory plus a small register window (LED, switches, timer) for a
// single-cycle core. Reads are combinational; writes land on the clock edge.
module dmem_mmio
    import mmio_pkg::*;
#(
    parameter int          RAM_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [15:0] sw,
    output logic [15:0] led,
    output logic        irq,
    output logic        fault
);

    localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

    sel_e        sel;
    logic [31:0] aligned;
    logic        misaligned_wr;
    logic        wr_ok;
    logic        ram_we;
    logic [31:0] ram_rdata;

    logic [15:0] led_q;
    logic [15:0] sw_meta;
    logic [15:0] sw_sync;
    logic [31:0] count_q;
    logic [31:0] cmp_q;
    logic        en_q;
    logic        pend_q;
    logic        fault_q;
    logic        match;

    assign aligned = {addr[31:2], 2'b00};

    always_comb begin
        sel = SEL_NONE;
        if ({2'b00, addr[31:2]} < 32'(RAM_WORDS)) sel = SEL_RAM;
        else                                      sel = decode_mmio(aligned, MMIO_BASE);
    end

    // Misaligned stores are dropped entirely; misaligned loads are harmless.
    assign misaligned_wr = MemWrite && (addr[1:0] != 2'b00);
    assign wr_ok         = MemWrite && (addr[1:0] == 2'b00);
    assign ram_we        = wr_ok && (sel == SEL_RAM);

    dm_ram #(
        .WORDS (RAM_WORDS),
        .AW    (AW)
    ) u_ram (
        .clk       (clk),
        .we        (ram_we),
        .word_addr (addr[AW+1:2]),
        .wdata     (writedata),
        .rdata     (ram_rdata)
    );

    assign match = (count_q == cmp_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q   <= '0;
            sw_meta <= '0;
            sw_sync <= '0;
            count_q <= '0;
            cmp_q   <= '0;
            en_q    <= 1'b0;
            pend_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;

            if (misaligned_wr) fault_q <= 1'b1;

            if (wr_ok && sel == SEL_LED) led_q <= writedata[15:0];
            if (wr_ok && sel == SEL_CMP) cmp_q <= writedata;

            // A CPU write to COUNT beats both increment and match reload.
            if (wr_ok && sel == SEL_COUNT) count_q <= writedata;
            else if (en_q)                 count_q <= match ? 32'd0 : count_q + 32'd1;

            if (wr_ok && sel == SEL_CTRL) en_q <= writedata[CTRL_EN];

            // A new match beats a simultaneous write-1-to-clear.
            if (en_q && match)
                pend_q <= 1'b1;
            else if (wr_ok && sel == SEL_CTRL && writedata[CTRL_PEND])
                pend_q <= 1'b0;
        end
    end

    always_comb begin
        readdata = 32'd0;
        case (sel)
            SEL_RAM:   readdata = ram_rdata;
            SEL_LED:   readdata = {16'd0, led_q};
            SEL_SW:    readdata = {16'd0, sw_sync};
            SEL_COUNT: readdata = count_q;
            SEL_CTRL:  readdata = {30'd0, pend_q, en_q};
            SEL_CMP:   readdata = cmp_q;
            default:   readdata = 32'd0;
        endcase
    end

    assign led   = led_q;
    assign irq   = pend_q;
    assign fault = fault_q;

endmodule

// File: doc/dmem_mmio.md
DMEM_MMIO -- requirements
Module: dmem_mmio

Interface
REQ-001 Parameter RAM_WORDS, default 1024, number of 32-bit data RAM words.
REQ-002 Parameter MMIO_BASE, default 32'h0000_7F00, base byte address of the register window.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 MemWrite  input  1  write strobe from the CPU core, valid for one cycle per store.
REQ-006 addr  input  32  byte address driven by the CPU aluout.
REQ-007 writedata  input  32  store data from the CPU.
REQ-008 readdata  output  32  load data to the CPU; combinational from addr.
REQ-009 sw  input  16  asynchronous board switches.
REQ-010 led  output  16  LED register contents.
REQ-011 irq  output  1  timer interrupt pending flag.
REQ-012 fault  output  1  sticky misaligned-access flag.

Function
REQ-013 The block SHALL serve word accesses only: addr[1:0] selects nothing and addr[31:2] is the word index.
REQ-014 RAM region SHALL be byte addresses 0 to 4*RAM_WORDS-1.
REQ-015 MMIO window SHALL decode these offsets from MMIO_BASE: 0x00 LED (RW, bits 15:0), 0x04 SW (RO), 0x08 COUNT (RW), 0x0C CTRL (bit0 EN RW, bit1 PEND read / write-1-to-clear), 0x10 CMP (RW).
REQ-016 Reads SHALL be combinational with zero-cycle latency, so a single-cycle core can sample readdata in the same cycle.
REQ-017 Writes SHALL take effect at the rising edge where MemWrite=1. A load of the same address in the next cycle SHALL return the new value.
REQ-018 Reads of unmapped addresses SHALL return 0. Writes to unmapped addresses and to SW SHALL be ignored.
REQ-019 Unused upper bits of LED, SW and CTRL SHALL read 0.
REQ-020 SW SHALL pass through a 2-flop synchronizer. A change on sw is visible in readdata 2 clock edges later.
REQ-021 Timer SHALL run only while EN=1: COUNT increments by 1 per cycle.
REQ-022 When EN=1 and COUNT==CMP, COUNT SHALL load 0 on the next edge instead of incrementing, and PEND SHALL set.
REQ-023 COUNT wraps from 32'hFFFF_FFFF to 0 with no PEND when CMP does not match.
REQ-024 A CPU write to COUNT in the same cycle as an increment or a match SHALL win over both. PEND still sets if the pre-write COUNT matched.
REQ-025 A write-1-to-clear of PEND in the same cycle as a new match SHALL leave PEND=1 (set wins).
REQ-026 irq SHALL equal PEND.
REQ-027 MemWrite=1 with addr[1:0]!=0 SHALL suppress the write and set fault. fault is cleared only by rst.
REQ-028 A misaligned read SHALL return data for addr[31:2] and SHALL NOT set fault.

Reset
REQ-029 On an edge with rst=1, LED, COUNT, CTRL, CMP, the synchronizer flops and fault SHALL become 0. Consequences: led=0, irq=0, fault=0.
REQ-030 RAM contents SHALL NOT be cleared by rst. Contents are undefined until first written.
REQ-031 rst SHALL override any coincident write or timer event. A reset asserted while the timer is running leaves the timer stopped with COUNT=0.

Structure
REQ-032 Shared package mmio_pkg SHALL hold the MMIO offset constants, CTRL bit indices and the default MMIO_BASE.
REQ-033 The RAM SHALL be a sub-module dm_ram with ports clk, we, word address, write data and async read data.
REQ-034 Decode, timer and synchronizer logic SHALL reside in dmem_mmio.

Verification
REQ-035 Bench SHALL store 32'hDEADBEEF to addr 0x10, then load 0x10 next cycle -> readdata=32'hDEADBEEF. Bench SHALL also load 0x2000 -> readdata=0.
REQ-036 Bench SHALL write CMP=3 and CTRL=1 with COUNT=0 -> COUNT reads 1,2,3 on successive cycles, then 0, and irq=1 from the cycle after COUNT=3.
REQ-037 With irq=1, bench SHALL write CTRL=32'h3 -> irq=0 next cycle. If the write coincides with a match -> irq stays 1.
REQ-038 Bench SHALL store to 0x12 -> fault=1 and RAM word 4 unchanged. A later aligned store SHALL NOT clear fault, and rst SHALL clear it.
REQ-039 Bench SHALL drive sw=16'hA5A5 -> load MMIO_BASE+4 returns 32'h0000_A5A5 after exactly 2 edges.
REQ-040 Bench SHALL assert rst while the timer runs with LED=16'hFFFF -> led=0, COUNT=0, EN=0, irq=0 after the edge, and RAM word 4 keeps its value.
